// File: rtl/iter_multiplier_pkg.sv
// CPU-wide multiplier defines plus the state type shared by iter_multiplier.
// Optional build macro consumed downstream: ITER_MUL_EARLY_TERM_EN.
`ifndef CPU_MUL_DEFINES
`define CPU_MUL_DEFINES
`define WORD_LENGTH  32
`define MUL_ST_IDLE  2'd0
`define MUL_ST_RUN   2'd1
`define MUL_ST_DONE  2'd2
`define MUL_CNT_BITS $clog2(`WORD_LENGTH + 1)
`endif

package iter_multiplier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = `MUL_ST_IDLE,
        ST_RUN  = `MUL_ST_RUN,
        ST_DONE = `MUL_ST_DONE
    } mul_state_t;

    // Step counter must hold WIDTH itself without wrapping.
    function automatic int cnt_bits(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/Adder.sv
// Unsigned ripple adder with carry-in/carry-out; bit 0 is the MSB.
module Adder #(
    parameter int WIDTH = `WORD_LENGTH
) (
    input  logic [0:WIDTH-1] inA,
    input  logic [0:WIDTH-1] inB,
    input  logic             inC,
    output logic [0:WIDTH-1] sum,
    output logic             outC
);

    assign {outC, sum} = {1'b0, inA} + {1'b0, inB} + {{WIDTH{1'b0}}, inC};

endmodule

// File: rtl/iter_multiplier.sv
// Sequential unsigned shift-and-add multiplier built around the shared Adder.
// Build option ITER_MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
//   state   | meaning
//   ST_IDLE | waiting for start
//   ST_RUN  | one shift-and-add step per edge, busy high
//   ST_DONE | product registers valid, done pulse
module iter_multiplier
#(
    parameter int WIDTH = `WORD_LENGTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [0:WIDTH-1] a,
    input  logic [0:WIDTH-1] b,
    output logic             busy,
    output logic             done,
    output logic [0:WIDTH-1] prodHi,
    output logic [0:WIDTH-1] prodLo
);
    import iter_multiplier_pkg::*;

    localparam int               CNT_W    = cnt_bits(WIDTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

    mul_state_t       r_state;
    mul_state_t       w_state_nxt;
    logic [0:WIDTH-1] r_acc;
    logic [0:WIDTH-1] r_mplier;
    logic [0:WIDTH-1] r_mcand;
    logic [0:WIDTH-1] r_prod_hi;
    logic [0:WIDTH-1] r_prod_lo;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [0:WIDTH-1] w_sum;
    logic             w_carry;
    logic [0:WIDTH-1] w_acc_step;
    logic [0:WIDTH-1] w_mpl_step;
    logic [0:WIDTH-1] w_acc_fin;
    logic [0:WIDTH-1] w_mpl_fin;
    logic             w_last;
    logic             w_accept;
    logic             w_step;

    Adder #(.WIDTH(WIDTH)) u_adder (
        .inA  (r_acc),
        .inB  (r_mcand),
        .inC  (1'b0),
        .sum  (w_sum),
        .outC (w_carry)
    );

    // Adder carry lands in the acc MSB, so the 2*WIDTH product never overflows.
    always_comb begin
        w_acc_step  = '0;
        w_mpl_step  = '0;
        w_count_nxt = r_count - CNT_W'(1);
        if (r_mplier[WIDTH-1]) begin
            {w_acc_step, w_mpl_step} = {w_carry, w_sum, r_mplier[0:WIDTH-2]};
        end else begin
            {w_acc_step, w_mpl_step} = {1'b0, r_acc, r_mplier[0:WIDTH-2]};
        end
    end

`ifdef ITER_MUL_EARLY_TERM_EN
    // Remaining steps would only shift zeros in, so collapse them into one barrel shift.
    always_comb begin
        w_last = ((w_mpl_step & ~({WIDTH{1'b1}} << w_count_nxt)) == '0);
        {w_acc_fin, w_mpl_fin} = {w_acc_step, w_mpl_step} >> w_count_nxt;
    end
`else
    always_comb begin
        w_last    = (w_count_nxt == '0);
        w_acc_fin = w_acc_step;
        w_mpl_fin = w_mpl_step;
    end
`endif

    assign w_accept = (r_state != ST_RUN) && start && !abort;
    assign w_step   = (r_state == ST_RUN) && !abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (abort)       w_state_nxt = ST_IDLE;
                else if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = w_accept ? ST_RUN : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc     <= '0;
            r_mplier  <= '0;
            r_mcand   <= '0;
            r_count   <= '0;
            r_prod_hi <= '0;
            r_prod_lo <= '0;
        end else if (w_accept) begin
            r_acc    <= '0;
            r_mplier <= b;
            r_mcand  <= a;
            r_count  <= CNT_INIT;
        end else if (w_step) begin
            r_acc    <= w_acc_fin;
            r_mplier <= w_mpl_fin;
            r_count  <= w_count_nxt;
            if (w_last) begin
                r_prod_hi <= w_acc_fin;
                r_prod_lo <= w_mpl_fin;
            end
        end
    end

    assign busy   = (r_state == ST_RUN);
    assign done   = (r_state == ST_DONE);
    assign prodHi = r_prod_hi;
    assign prodLo = r_prod_lo;

endmodule

// File: doc/iter_multiplier.md
Name: iter_multiplier

Overview:
- Sequential unsigned WIDTH x WIDTH -> 2*WIDTH shift-and-add multiplier.
- Sits directly upstream of the existing Adder. Each cycle it drives the Adder with the partial-product accumulator and the multiplicand, then consumes the Adder's sum and carry-out.
- Used by the execute stage for MUL-type instructions. Start/busy/done handshake toward the pipeline control.

Parameters:
- WIDTH, default `WORD_LENGTH, operand width. Bit numbering is [0:WIDTH-1], bit 0 = MSB.

Ports:
- clk  in  1  system clock, all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  request a multiply; sampled on the rising edge
- abort  in  1  synchronous cancel of a running multiply
- a  in  WIDTH  multiplicand, sampled with start
- b  in  WIDTH  multiplier, sampled with start
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle completion pulse
- prodHi  out  WIDTH  upper half of the product (bits 0..WIDTH-1 of the 2*WIDTH result)
- prodLo  out  WIDTH  lower half of the product

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; busy=0, done=0, prodHi=0, prodLo=0; internal acc, mplier, mcand and count all 0.
- States:
  - IDLE: start=1 -> latch mcand=a, mplier=b, acc=0, count=WIDTH; go to RUN.
  - RUN: each edge performs one step:
    - If mplier[WIDTH-1]=1: {c,sum} = acc + mcand (Adder, inC=0). Otherwise {c,sum} = {0,acc}.
    - Shift {c,sum,mplier} right by 1 into {acc,mplier}.
    - count = count-1.
    - When count reaches 0, go to DONE.
  - DONE: prodHi=acc, prodLo=mplier (these registers are written only on this transition). done=1 for exactly this one cycle. Next edge -> IDLE, or -> RUN if start=1 (back-to-back start is accepted in DONE).
- busy=1 in RUN only.
- Latency: done is high in the cycle after the WIDTH-th RUN edge, i.e. WIDTH+1 edges after the edge that accepted start.
- start is ignored while in RUN; operands are never re-sampled mid-operation.
- abort=1 in RUN: next edge -> IDLE. No done pulse; prodHi/prodLo keep their previous values. abort has priority over completion on the same edge. abort in IDLE or DONE has no effect, but abort and start together in IDLE or DONE: abort wins, start is dropped.
- rst asserted mid-operation: immediate return to the reset values above; no done pulse.
- Arithmetic: unsigned only. The carry-out of the Adder is always captured into the acc MSB, so no overflow is possible; the full 2*WIDTH product is exact.
- a=0 or b=0: still runs the full WIDTH steps unless the optional feature below is compiled in; result 0.
- count is ceil(log2(WIDTH+1)) bits wide and must not wrap.

Optional Feature:
- Macro: ITER_MUL_EARLY_TERM_EN.
- Defined:
  - In RUN, if all unprocessed mplier bits are 0 (mplier upper bits, excluding the already-shifted product bits), the block finishes immediately. {acc,mplier} is shifted right by count in one barrel shift, then the block goes to DONE.
  - At least one RUN step is always taken.
  - Latency = (index from LSB of the highest set bit of b) + 2 edges. For b=0 the latency is 2 edges.
  - Results are identical to the non-early-termination build.
- Not defined: fixed WIDTH+1 latency. No barrel shifter is synthesised.

Decomposition:
- Shared include (the CPU-wide defines file):
  - `WORD_LENGTH
  - state encodings: `MUL_ST_IDLE, `MUL_ST_RUN, `MUL_ST_DONE (2-bit)
  - `MUL_CNT_BITS
- Sub-module: one instance of the existing Adder (WIDTH=WIDTH, inC tied 0), driven from acc and mcand. No new sub-module.
- The state machine and shift datapath stay in iter_multiplier.

Test Plan (WIDTH=32 unless noted):
- Basic and latency:
  - Stimulus: reset, then start with a=10, b=5.
  - Required: busy high for 32 cycles; done high for exactly 1 cycle, 33 edges after start; prodHi=0x00000000, prodLo=0x00000032.
- Maximum operands:
  - Stimulus: a=0xFFFFFFFF, b=0xFFFFFFFF.
  - Required: prodHi=0xFFFFFFFE, prodLo=0x00000001; Adder carry-out exercised every step.
- Start while busy, then back-to-back:
  - Stimulus: start a=3, b=7; pulse start a=9, b=9 at cycle 10; then start again exactly in the DONE cycle with a=2, b=0x80000000.
  - Required: first result 21 (the mid-run start is ignored); second operation begins immediately; prodHi=0x00000001, prodLo=0x00000000.
- Abort:
  - Stimulus: complete 6*7, then start 100*100 and assert abort at RUN cycle 15.
  - Required: IDLE next cycle; no done pulse; prodLo stays 42.
- Async reset mid-run:
  - Stimulus: drop rst at an arbitrary phase within the clock period during RUN.
  - Required: outputs go to 0 without waiting for a clock edge; after release, a new 4*4 yields 16.
- Early termination (ITER_MUL_EARLY_TERM_EN defined):
  - Stimulus: a=0x12345678, b=1; then b=0.
  - Required: done after 2 edges in both cases; products 0x00000000_12345678 and 0.
